// File: rtl/regbank_sb.sv
// regbank_sb: parametrised 2R/1W register bank with write bypass and per-register busy scoreboard (optional REGBANK_SB_ZERO_REG_EN hardwires register 0)
module regbank_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  output logic              rbusy1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  output logic              rbusy2,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_a,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we, ie;
  // effective enables; bypass must stay silent while reset is held
`ifdef REGBANK_SB_ZERO_REG_EN
  assign we = w_en && rst_n && (wa != '0);
  assign ie = iss_en && rst_n && (iss_a != '0);
`else
  assign we = w_en && rst_n;
  assign ie = iss_en && rst_n;
`endif
  // next busy vector: write clears, issue sets last so it wins on collision
  always_comb begin
    busy_d = busy_q;
    if (we) busy_d[wa] = 1'b0;
    if (ie) busy_d[iss_a] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
  end
  // register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end
  // scoreboard state and its registered population count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  assign busy_cnt = cnt_q;
  // read port 1 with optional same-cycle forwarding
  always_comb begin
    rd1    = regs_q[ra1];
    rbusy1 = busy_q[ra1];
    if (BYPASS != 0 && we && wa == ra1) begin
      rd1    = wd;
      rbusy1 = ie && iss_a == ra1;
    end
`ifdef REGBANK_SB_ZERO_REG_EN
    if (ra1 == '0) begin
      rd1    = '0;
      rbusy1 = 1'b0;
    end
`endif
  end
  // read port 2 with optional same-cycle forwarding
  always_comb begin
    rd2    = regs_q[ra2];
    rbusy2 = busy_q[ra2];
    if (BYPASS != 0 && we && wa == ra2) begin
      rd2    = wd;
      rbusy2 = ie && iss_a == ra2;
    end
`ifdef REGBANK_SB_ZERO_REG_EN
    if (ra2 == '0) begin
      rd2    = '0;
      rbusy2 = 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb: directed self-checking bench driving a BYPASS=1 and a BYPASS=0 bank in parallel
module tb_regbank_sb;
`ifdef REGBANK_SB_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 1'b0, rst_n;
  logic [3:0] ra1, ra2, wa, iss_a;
  logic [31:0] wd;
  logic w_en, iss_en;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic rb1_b, rb2_b, rb1_n, rb2_n;
  logic [4:0] cnt_b, cnt_n;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  regbank_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .rd1(rd1_b), .rbusy1(rb1_b),
    .ra2(ra2), .rd2(rd2_b), .rbusy2(rb2_b), .w_en(w_en), .wa(wa), .wd(wd),
    .iss_en(iss_en), .iss_a(iss_a), .busy_cnt(cnt_b));
  regbank_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .rd1(rd1_n), .rbusy1(rb1_n),
    .ra2(ra2), .rd2(rd2_n), .rbusy2(rb2_n), .w_en(w_en), .wa(wa), .wd(wd),
    .iss_en(iss_en), .iss_a(iss_a), .busy_cnt(cnt_n));
  task automatic edge_idle();
    @(posedge clk);
    #1;
    w_en = 1'b0;
    iss_en = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b1; w_en = 0; iss_en = 0; ra1 = 0; ra2 = 0; wa = 0; wd = 0; iss_a = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd1_b !== 32'h0 || cnt_b !== 5'd0 || rb1_b !== 1'b0) begin failures++; $display("FAIL reset_init rd1=%h cnt=%0d rbusy1=%b exp 0/0/0", rd1_b, cnt_b, rb1_b); end
    @(negedge clk) rst_n = 1'b1;
    w_en = 1; wa = 3; wd = 32'hDEADBEEF; iss_en = 1; iss_a = 4; ra1 = 3;
    edge_idle();
    checks++; if (rd1_b !== 32'hDEADBEEF || rd1_n !== 32'hDEADBEEF || cnt_b !== 5'd1) begin failures++; $display("FAIL reset_prewrite rd1=%h/%h cnt=%0d exp deadbeef/1", rd1_b, rd1_n, cnt_b); end
    @(negedge clk);
    w_en = 1; wa = 3; wd = 32'h55; rst_n = 1'b0;
    #1;
    checks++; if (rd1_b !== 32'h0 || rd1_n !== 32'h0 || cnt_b !== 5'd0 || cnt_n !== 5'd0) begin failures++; $display("FAIL reset_async rd1=%h/%h cnt=%0d/%0d exp 0", rd1_b, rd1_n, cnt_b, cnt_n); end
    @(posedge clk); #1;
    checks++; if (rd1_n !== 32'h0) begin failures++; $display("FAIL reset_held rd1=%h exp 0", rd1_n); end
    @(negedge clk) rst_n = 1'b1; w_en = 0;
  endtask
  task automatic test_sweep();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk) w_en = 1; wa = 4'(a); wd = 32'(2 * a);
      edge_idle();
    end
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a); ra2 = 4'(15 - a);
      #1;
      checks++; if (rd1_n !== 32'(2 * a) || rd1_b !== 32'(2 * a)) begin failures++; $display("FAIL sweep_rd1 a=%0d got=%h/%h exp=%h", a, rd1_b, rd1_n, 32'(2 * a)); end
      checks++; if (rd2_n !== 32'(2 * (15 - a)) || rd2_b !== 32'(2 * (15 - a))) begin failures++; $display("FAIL sweep_rd2 a=%0d got=%h/%h exp=%h", a, rd2_b, rd2_n, 32'(2 * (15 - a))); end
    end
    @(negedge clk) w_en = 1; wa = 0; wd = 32'hFFFF; ra1 = 0; ra2 = 0;
    #1;
    checks++; if (rd1_b !== (ZR ? 32'h0 : 32'hFFFF) || rd2_b !== rd1_b) begin failures++; $display("FAIL r0_bypass got=%h/%h exp=%h", rd1_b, rd2_b, ZR ? 32'h0 : 32'hFFFF); end
    edge_idle();
    checks++; if (rd1_n !== (ZR ? 32'h0 : 32'hFFFF)) begin failures++; $display("FAIL r0_write got=%h exp=%h", rd1_n, ZR ? 32'h0 : 32'hFFFF); end
  endtask
  task automatic test_bypass();
    @(negedge clk) w_en = 1; wa = 5; wd = 32'h1234; ra1 = 5; ra2 = 5;
    #1;
    checks++; if (rd1_b !== 32'h1234 || rd2_b !== 32'h1234) begin failures++; $display("FAIL bypass_fwd got=%h/%h exp=1234", rd1_b, rd2_b); end
    checks++; if (rd1_n !== 32'hA || rd2_n !== 32'hA) begin failures++; $display("FAIL nobypass_old got=%h/%h exp=a", rd1_n, rd2_n); end
    edge_idle();
    checks++; if (rd1_n !== 32'h1234 || rd1_b !== 32'h1234) begin failures++; $display("FAIL bypass_after got=%h/%h exp=1234", rd1_b, rd1_n); end
  endtask
  task automatic test_scoreboard();
    @(negedge clk) iss_en = 1; iss_a = 7; ra1 = 7;
    edge_idle();
    checks++; if (rb1_b !== 1'b1 || cnt_b !== 5'd1 || cnt_n !== 5'd1) begin failures++; $display("FAIL sb_issue rbusy1=%b cnt=%0d/%0d exp 1/1", rb1_b, cnt_b, cnt_n); end
    @(negedge clk) iss_en = 1; iss_a = 7;
    edge_idle();
    checks++; if (cnt_b !== 5'd1 || rb1_n !== 1'b1) begin failures++; $display("FAIL sb_reissue cnt=%0d rbusy1=%b exp 1/1", cnt_b, rb1_n); end
    @(negedge clk) w_en = 1; wa = 7; wd = 32'h77;
    #1;
    checks++; if (rb1_b !== 1'b0 || rb1_n !== 1'b1) begin failures++; $display("FAIL sb_bypass_busy got=%b/%b exp 0/1", rb1_b, rb1_n); end
    edge_idle();
    checks++; if (rb1_b !== 1'b0 || rb1_n !== 1'b0 || cnt_b !== 5'd0) begin failures++; $display("FAIL sb_clear rbusy1=%b/%b cnt=%0d exp 0/0/0", rb1_b, rb1_n, cnt_b); end
  endtask
  task automatic test_collision();
    @(negedge clk) w_en = 1; wa = 9; wd = 32'hABCD; iss_en = 1; iss_a = 9; ra1 = 9; ra2 = 9;
    #1;
    checks++; if (rd1_b !== 32'hABCD || rb1_b !== 1'b1 || rb2_b !== 1'b1) begin failures++; $display("FAIL coll_bypass rd1=%h rbusy=%b%b exp abcd/11", rd1_b, rb1_b, rb2_b); end
    edge_idle();
    checks++; if (rd1_n !== 32'hABCD || rb1_n !== 1'b1 || cnt_n !== 5'd1) begin failures++; $display("FAIL coll_after rd1=%h rbusy1=%b cnt=%0d exp abcd/1/1", rd1_n, rb1_n, cnt_n); end
    @(negedge clk) w_en = 1; wa = 9; wd = 32'h99; iss_en = 1; iss_a = 2; ra2 = 2;
    edge_idle();
    checks++; if (rb1_n !== 1'b0 || rb2_n !== 1'b1 || rd1_n !== 32'h99 || cnt_b !== 5'd1) begin failures++; $display("FAIL diff_addr rbusy=%b%b rd1=%h cnt=%0d exp 0/1/99/1", rb1_n, rb2_n, rd1_n, cnt_b); end
    @(negedge clk) w_en = 1; wa = 2; wd = 32'h22;
    edge_idle();
    checks++; if (cnt_b !== 5'd0 || rb2_b !== 1'b0) begin failures++; $display("FAIL diff_clear cnt=%0d rbusy2=%b exp 0/0", cnt_b, rb2_b); end
  endtask
  task automatic test_saturation();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk) iss_en = 1; iss_a = 4'(a);
      edge_idle();
    end
    ra1 = 0; ra2 = 15;
    #1;
    checks++; if (cnt_b !== (ZR ? 5'd15 : 5'd16) || cnt_n !== cnt_b) begin failures++; $display("FAIL sat_full cnt=%0d/%0d exp %0d", cnt_b, cnt_n, ZR ? 15 : 16); end
    checks++; if (rb1_b !== !ZR || rb2_b !== 1'b1) begin failures++; $display("FAIL sat_busy rbusy=%b%b exp %b1", rb1_b, rb2_b, !ZR); end
    for (int a = 0; a < 16; a++) begin
      @(negedge clk) w_en = 1; wa = 4'(a); wd = 32'(a);
      edge_idle();
    end
    checks++; if (cnt_b !== 5'd0 || cnt_n !== 5'd0 || rb1_b !== 1'b0 || rb2_b !== 1'b0) begin failures++; $display("FAIL sat_empty cnt=%0d/%0d rbusy=%b%b exp 0", cnt_b, cnt_n, rb1_b, rb2_b); end
  endtask
  initial begin
    test_reset();
    test_sweep();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regbank_sb.md
Name: regbank_sb

Overview:
- Parametrised successor to the 16x32 register bank: 2 asynchronous read ports, 1 write port, width and depth set by parameters.
- Adds asynchronous clear and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: an issue port marks a destination busy, and the write that lands on it clears the mark.
- Sits between the decode/issue stage and writeback of the CPU datapath; the issue logic stalls on the busy flags.

Parameters:
- DATA_W, 32, bits per register.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers (derived, not overridable).
- BYPASS, 1, 1 = read data forwards same-cycle write data; 0 = reads return the stored value only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ra1  input  ADDR_W  read address, port 1.
- rd1  output  DATA_W  read data, port 1.
- rbusy1  output  1  busy flag of register ra1.
- ra2  input  ADDR_W  read address, port 2.
- rd2  output  DATA_W  read data, port 2.
- rbusy2  output  1  busy flag of register ra2.
- w_en  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- iss_en  input  1  issue strobe: mark iss_a busy.
- iss_a  input  ADDR_W  destination address being issued.
- busy_cnt  output  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - all DEPTH registers = 0, all busy bits = 0, busy_cnt = 0.
  - rd1/rd2 therefore read 0 and rbusy1/rbusy2 read 0 while reset is held.
- Reset mid-operation discards pending writes and issues in that cycle. First update happens on the first rising edge with rst_n=1.
- Write: on rising edge with w_en=1, r[wa] <= wd and busy[wa] <= 0.
- Issue: on rising edge with iss_en=1, busy[iss_a] <= 1.
- Simultaneous w_en and iss_en to the same address: data is written and busy ends at 1 (issue wins, since a new producer is in flight).
- Different addresses: both take effect independently.
- Write to a non-busy register is legal: data written, busy stays 0.
- Issue to an already-busy register: stays 1, busy_cnt unchanged.
- Reads are combinational, zero latency.
  - BYPASS=1: if w_en=1 and wa==raN, rdN = wd and rbusyN = 0, unless iss_en=1 and iss_a==raN, in which case rbusyN = 1. Otherwise rdN = r[raN] and rbusyN = busy[raN].
  - BYPASS=0: rdN = r[raN] and rbusyN = busy[raN]; a write becomes visible the cycle after the edge.
- Both read ports may address the same register, including the write target, with identical results.
- busy_cnt is a registered population count of the busy vector, updated each edge to the post-update count. Range 0..DEPTH; DEPTH is representable because of the extra bit.
- Addresses are full-range; no out-of-range case exists.

Optional Feature:
- Macro REGBANK_SB_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired: rdN = 0 and rbusyN = 0 whenever raN == 0, including under bypass.
  - writes to address 0 are discarded; issues to address 0 are ignored.
  - busy[0] never counts toward busy_cnt.
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset: write 0xDEADBEEF to r3, assert rst_n=0 between edges -> rd1 (ra1=3) = 0 immediately with no edge; busy_cnt = 0.
- Write/read sweep: write wd = 2*a to every a = 0..15, then read ra1 = a, ra2 = 15-a -> rd1 = 2*a, rd2 = 2*(15-a). Under ZERO_REG_EN, address 0 reads 0.
- Bypass: BYPASS=1, w_en=1, wa=5, wd=0x1234, ra1=5 in the same cycle -> rd1 = 0x1234 before the edge. BYPASS=0 -> old value before the edge, 0x1234 after.
- Scoreboard:
  - iss_en with iss_a=7 -> rbusy1 (ra1=7) = 1, busy_cnt = 1.
  - then w_en, wa=7 -> rbusy1 = 0 after the edge, busy_cnt = 0.
- Collision: w_en, wa=9 and iss_en, iss_a=9 on the same edge -> r9 = wd, busy[9] = 1, busy_cnt +1.
- Saturation: issue all 16 addresses -> busy_cnt = 16, or 15 under ZERO_REG_EN. Then write them all -> busy_cnt = 0.
